// File: rtl/button_mode_controller_if.sv
// -----------------------------------------------------------------------------
// button_mode_controller_if
// Groups the button inputs and the mode/strobe outputs of the clock's button
// front end.
//   btn_mode   : raw asynchronous MODE button, active-high
//   btn_inc    : raw asynchronous INC button, active-high
//   mode       : 00 RUN, 01 SET_HR, 10 SET_MIN, 11 SET_SEC
//   run_en     : 1 while mode is RUN
//   inc_pulse  : one-cycle increment strobe for the field selected by mode
//   mode_pulse : one-cycle strobe on each accepted MODE press
// The master modport drives the buttons (board / testbench side).
// The slave modport is the controller side.
// -----------------------------------------------------------------------------
interface button_mode_controller_if;
    logic       btn_mode;
    logic       btn_inc;
    logic [1:0] mode;
    logic       run_en;
    logic       inc_pulse;
    logic       mode_pulse;

    modport master (
        output btn_mode, btn_inc,
        input  mode, run_en, inc_pulse, mode_pulse
    );

    modport slave (
        input  btn_mode, btn_inc,
        output mode, run_en, inc_pulse, mode_pulse
    );
endinterface

// File: rtl/button_mode_controller.sv
// -----------------------------------------------------------------------------
// button_mode_controller
//
// Purpose:
//   Front end for the clock's MODE and INC push-buttons.
//   Each button goes through the following stages:
//     - a two-flop synchroniser;
//     - a counter debouncer;
//     - a registered rising-edge detector.
//   The resulting press pulses drive the RUN/SET_HR/SET_MIN/SET_SEC state
//   machine and the gated increment strobe.
//
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous reset, active-low
//   bus   : button_mode_controller_if.slave
//           (btn_mode, btn_inc in; mode, run_en, inc_pulse, mode_pulse out)
//
// Configuration:
//   AUTO_REPEAT_EN
//     Defined   : holding INC in a SET state produces a first repeat strobe
//                 REPEAT_DELAY cycles after the press strobe, and then one
//                 strobe every REPEAT_PERIOD cycles.
//     Undefined : one strobe per debounced INC press; no repeat logic exists.
// -----------------------------------------------------------------------------
module button_mode_controller #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 50,
    parameter int REPEAT_PERIOD   = 10,
    parameter int CNT_W           = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    button_mode_controller_if.slave  bus
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_HR  = 2'b01,
        SET_MIN = 2'b10,
        SET_SEC = 2'b11
    } mode_e;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 || CNT_W < 2) begin : g_bad_params
        $error("button_mode_controller: illegal parameter combination");
    end

    // Bit 0 = MODE, bit 1 = INC
    logic [1:0] btn_raw;
    logic [1:0] press;

    assign btn_raw = {bus.btn_inc, bus.btn_mode};

`ifdef AUTO_REPEAT_EN
    logic inc_level;
`endif

    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        logic             sync1_q;
        logic             sync2_q;
        logic             level_q;
        logic             level_prev_q;
        logic             press_q;
        logic             seen_low_q;
        logic [CNT_W-1:0] cnt_q;
        logic             level_ref;

        // Until the button has been debounced low once since reset, treat it
        // as held. This way, a press that spans reset release is never
        // turned into a pulse.
        assign level_ref = level_q | ~seen_low_q;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sync1_q      <= 1'b0;
                sync2_q      <= 1'b0;
                level_q      <= 1'b0;
                level_prev_q <= 1'b0;
                press_q      <= 1'b0;
                seen_low_q   <= 1'b0;
                cnt_q        <= '0;
            end else begin
                sync1_q      <= btn_raw[gi];
                sync2_q      <= sync1_q;
                level_prev_q <= level_q;
                press_q      <= level_q & ~level_prev_q;
                if (sync2_q == level_ref) begin
                    cnt_q <= '0;
                end else if (cnt_q == DB_LAST) begin
                    cnt_q <= '0;
                    if (seen_low_q) begin
                        level_q <= ~level_q;
                    end else begin
                        seen_low_q <= 1'b1;
                    end
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end

        assign press[gi] = press_q;

`ifdef AUTO_REPEAT_EN
        if (gi == 1) begin : g_inc_level
            assign inc_level = level_q;
        end
`endif
    end

    mode_e state_q;
    mode_e state_d;
    logic  run_en_q;
    logic  inc_pulse_q;
    logic  inc_pulse_d;
    logic  mode_pulse_c;

`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic             armed_q;
    logic             armed_d;
    logic             in_delay_q;
    logic             in_delay_d;
    logic [CNT_W-1:0] rep_cnt_q;
    logic [CNT_W-1:0] rep_cnt_d;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RUN;
            run_en_q    <= 1'b1;
            inc_pulse_q <= 1'b0;
`ifdef AUTO_REPEAT_EN
            armed_q     <= 1'b0;
            in_delay_q  <= 1'b0;
            rep_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            run_en_q    <= (state_d == RUN);
            inc_pulse_q <= inc_pulse_d;
`ifdef AUTO_REPEAT_EN
            armed_q     <= armed_d;
            in_delay_q  <= in_delay_d;
            rep_cnt_q   <= rep_cnt_d;
`endif
        end
    end

    // MODE has priority. A simultaneous INC press is dropped, and any
    // mode change disarms the repeat.
    always_comb begin
        state_d      = state_q;
        inc_pulse_d  = 1'b0;
        mode_pulse_c = 1'b0;
`ifdef AUTO_REPEAT_EN
        armed_d      = armed_q;
        in_delay_d   = in_delay_q;
        rep_cnt_d    = rep_cnt_q;
`endif
        if (press[0]) begin
            state_d      = mode_e'(state_q + 2'd1);
            mode_pulse_c = 1'b1;
`ifdef AUTO_REPEAT_EN
            armed_d      = 1'b0;
`endif
        end else if (press[1] && state_q != RUN) begin
            inc_pulse_d = 1'b1;
`ifdef AUTO_REPEAT_EN
            armed_d     = 1'b1;
            in_delay_d  = 1'b1;
            rep_cnt_d   = '0;
        end else if (armed_q && inc_level) begin
            // rep_cnt counts cycles since the last strobe.
            // The first gap is REPEAT_DELAY; later gaps are REPEAT_PERIOD.
            if (rep_cnt_q == (in_delay_q ? DELAY_LAST : PERIOD_LAST)) begin
                inc_pulse_d = 1'b1;
                in_delay_d  = 1'b0;
                rep_cnt_d   = '0;
            end else if (rep_cnt_q != '1) begin
                rep_cnt_d = rep_cnt_q + 1'b1;
            end
        end else begin
            armed_d = 1'b0;
`endif
        end
    end

    assign bus.mode       = state_q;
    assign bus.run_en     = run_en_q;
    assign bus.inc_pulse  = inc_pulse_q;
    assign bus.mode_pulse = mode_pulse_c;

endmodule

// File: tb/tb_button_mode_controller.sv
module tb_button_mode_controller;

    localparam int DB = 4;
    localparam int RD = 8;
    localparam int RP = 3;

`ifdef AUTO_REPEAT_EN
    localparam bit REPEAT_ON = 1'b1;
`else
    localparam bit REPEAT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    button_mode_controller_if bif();

    button_mode_controller #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bif)
    );

    int n_vec = 0;
    int n_err = 0;

    // ---------------- behavioural reference model ----------------
    // Rules are applied per button:
    //   - a raw sample reaches the debouncer two edges later;
    //   - the level flips once D consecutive samples agree on the other value;
    //   - the press pulse appears one cycle after the level rises;
    //   - the press is acted on in the following cycle.
    // Repeat strobes are scheduled arithmetically from the press strobe time.
    logic       mr1[2], mr2[2], mlast[2], mseen[2], mdb[2], mdbp[2], mpress[2];
    int         mrun[2];
    logic [1:0] mmode;
    logic       marmed, exp_inc, exp_mp;
    int         mt0, mcyc;

    logic [4:0] exp_vec, obs_vec;
    assign exp_vec = {mmode, mmode == 2'd0, exp_inc, exp_mp};
    assign obs_vec = {bif.mode, bif.run_en, bif.inc_pulse, bif.mode_pulse};

    task automatic model_step(input logic m, input logic i, input logic r);
        logic [1:0] raw;
        logic [1:0] np;
        logic       s;
        raw = {i, m};
        if (!r) begin
            for (int b = 0; b < 2; b++) begin
                mr1[b] = 0; mr2[b] = 0; mlast[b] = 0; mrun[b] = 0;
                mseen[b] = 0; mdb[b] = 0; mdbp[b] = 0; mpress[b] = 0;
            end
            mmode = 0; marmed = 0; exp_inc = 0; exp_mp = 0; mcyc = 0; mt0 = 0;
            return;
        end
        exp_inc = 0;
        if (mpress[0]) begin
            mmode  = mmode + 2'd1;
            marmed = 0;
        end else if (mpress[1] && mmode != 2'd0) begin
            exp_inc = 1;
            marmed  = REPEAT_ON;
            mt0     = mcyc + 1;
        end else if (marmed) begin
            if (!mdb[1]) marmed = 0;
            else if ((mcyc + 1 - mt0) >= RD && ((mcyc + 1 - mt0 - RD) % RP) == 0) exp_inc = 1;
        end
        for (int b = 0; b < 2; b++) begin
            np[b]   = mdb[b] & ~mdbp[b];
            mdbp[b] = mdb[b];
            s       = mr2[b];
            mr2[b]  = mr1[b];
            mr1[b]  = raw[b];
            if (s == mlast[b]) mrun[b]++;
            else begin mrun[b] = 1; mlast[b] = s; end
            if (!mseen[b]) begin
                if (s == 1'b0 && mrun[b] >= DB) mseen[b] = 1;
            end else if (s != mdb[b] && mrun[b] >= DB) begin
                mdb[b] = s;
            end
        end
        mpress[0] = np[0];
        mpress[1] = np[1];
        exp_mp    = np[0];
        mcyc++;
    endtask

    task automatic tick(input logic m, input logic i, input logic r);
        bif.btn_mode = m;
        bif.btn_inc  = i;
        rst_n        = r;
        @(posedge clk);
        model_step(m, i, r);
        @(negedge clk);
    endtask

    // Stimulus entries are {rst_n, inc, mode}
    logic [2:0] stim_q[$];

    task automatic push_seg(input logic r, input logic m, input logic i, input int len);
        for (int k = 0; k < len; k++) stim_q.push_back({r, i, m});
    endtask

    task automatic push_press(input logic m, input logic i, input int hi, input int lo);
        push_seg(1, m, i, hi);
        push_seg(1, 0, 0, lo);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int mp_cnt = 0;
        int mp_idx = -1;
        int hi_start;
        stim_q.delete();
        push_seg(0, 1, 0, 3);
        push_seg(1, 1, 0, 12);
        push_seg(1, 0, 0, 4);
        hi_start = stim_q.size();
        push_seg(1, 1, 0, 10);
        push_seg(1, 0, 0, 8);
        foreach (stim_q[k]) begin
            tick(stim_q[k][0], stim_q[k][1], stim_q[k][2]);
            n_vec++;
            if (obs_vec !== exp_vec) begin
                n_err++;
                $display("FAIL reset_model idx %0d: got %b want %b", k, obs_vec, exp_vec);
            end
            if (k < 3) begin
                n_vec++;
                if (obs_vec !== 5'b00100) begin
                    n_err++;
                    $display("FAIL reset_state idx %0d: got %b want 00100", k, obs_vec);
                end
            end
            if (bif.mode_pulse === 1'b1) begin
                mp_cnt++;
                if (mp_idx < 0) mp_idx = k;
            end
        end
        n_vec++;
        if (mp_cnt != 1) begin
            n_err++;
            $display("FAIL reset_held_press_count: got %0d want 1", mp_cnt);
        end
        n_vec++;
        if (mp_idx != hi_start + 2 + DB) begin
            n_err++;
            $display("FAIL reset_repress_time: got idx %0d want %0d", mp_idx, hi_start + 2 + DB);
        end
        $display("test_reset: %0d mode pulses", mp_cnt);
    endtask

    task automatic test_debounce();
        int mp_glitch = 0;
        int mp_idx = -1;
        int hi_start, glitch_end;
        logic [1:0] mode_after = 2'bxx;
        stim_q.delete();
        push_seg(0, 0, 0, 2);
        push_seg(1, 0, 0, 6);
        for (int g = 0; g < 5; g++) push_press(1, 0, DB - 1, 3);
        glitch_end = stim_q.size();
        push_seg(1, 0, 0, 4);
        hi_start = stim_q.size();
        push_press(1, 0, 10, 8);
        foreach (stim_q[k]) begin
            tick(stim_q[k][0], stim_q[k][1], stim_q[k][2]);
            n_vec++;
            if (obs_vec !== exp_vec) begin
                n_err++;
                $display("FAIL debounce_model idx %0d: got %b want %b", k, obs_vec, exp_vec);
            end
            if (bif.mode_pulse === 1'b1 && k < glitch_end) mp_glitch++;
            if (mp_idx >= 0 && k == mp_idx + 1) mode_after = bif.mode;
            if (bif.mode_pulse === 1'b1 && k >= hi_start && mp_idx < 0) mp_idx = k;
        end
        n_vec++;
        if (mp_glitch != 0) begin
            n_err++;
            $display("FAIL debounce_glitch_pulses: got %0d want 0", mp_glitch);
        end
        n_vec++;
        if (mp_idx != hi_start + 2 + DB) begin
            n_err++;
            $display("FAIL debounce_latency: got idx %0d want %0d", mp_idx, hi_start + 2 + DB);
        end
        n_vec++;
        if (mode_after !== 2'b01) begin
            n_err++;
            $display("FAIL debounce_mode_next: got %b want 01", mode_after);
        end
        $display("test_debounce: pulse at idx %0d, mode then %b", mp_idx, mode_after);
    endtask

    task automatic test_mode_wrap();
        int mp_cnt = 0;
        bit grab = 0;
        logic [2:0] seen[$];
        logic [2:0] got, want;
        stim_q.delete();
        push_seg(0, 0, 0, 2);
        push_seg(1, 0, 0, 8);
        for (int p = 0; p < 4; p++) push_press(1, 0, 8, 8);
        foreach (stim_q[k]) begin
            tick(stim_q[k][0], stim_q[k][1], stim_q[k][2]);
            n_vec++;
            if (obs_vec !== exp_vec) begin
                n_err++;
                $display("FAIL wrap_model idx %0d: got %b want %b", k, obs_vec, exp_vec);
            end
            if (grab) begin
                seen.push_back({bif.mode, bif.run_en});
                grab = 0;
            end
            if (bif.mode_pulse === 1'b1) begin
                mp_cnt++;
                grab = 1;
            end
        end
        n_vec++;
        if (mp_cnt != 4) begin
            n_err++;
            $display("FAIL wrap_pulse_count: got %0d want 4", mp_cnt);
        end
        for (int j = 0; j < 4; j++) begin
            want = {2'((j + 1) % 4), (j == 3)};
            got  = (j < seen.size()) ? seen[j] : 3'bxxx;
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL wrap_step%0d {mode,run_en}: got %b want %b", j, got, want);
            end
        end
        $display("test_mode_wrap: %0d mode pulses", mp_cnt);
    endtask

    task automatic test_inc_gating();
        int inc_run = 0;
        int inc_set = 0;
        int run_end;
        stim_q.delete();
        push_seg(0, 0, 0, 2);
        push_seg(1, 0, 0, 8);
        push_press(0, 1, 8, 8);
        run_end = stim_q.size();
        push_press(1, 0, 8, 8);
        push_press(1, 0, 8, 8);
        push_press(0, 1, 6, 14);
        foreach (stim_q[k]) begin
            tick(stim_q[k][0], stim_q[k][1], stim_q[k][2]);
            n_vec++;
            if (obs_vec !== exp_vec) begin
                n_err++;
                $display("FAIL gating_model idx %0d: got %b want %b", k, obs_vec, exp_vec);
            end
            if (bif.inc_pulse === 1'b1) begin
                if (k < run_end) inc_run++;
                else inc_set++;
            end
        end
        n_vec++;
        if (inc_run != 0) begin
            n_err++;
            $display("FAIL gating_run_inc: got %0d want 0", inc_run);
        end
        n_vec++;
        if (inc_set != 1) begin
            n_err++;
            $display("FAIL gating_set_inc: got %0d want 1", inc_set);
        end
        n_vec++;
        if (bif.mode !== 2'b10) begin
            n_err++;
            $display("FAIL gating_mode: got %b want 10", bif.mode);
        end
        $display("test_inc_gating: run %0d, set %0d inc pulses", inc_run, inc_set);
    endtask

    task automatic test_auto_repeat();
        int got_idx[$];
        int want_idx[$];
        int s, bound, t;
        stim_q.delete();
        push_seg(0, 0, 0, 2);
        push_seg(1, 0, 0, 8);
        push_press(1, 0, 8, 8);
        s = stim_q.size();
        push_press(0, 1, 30, 15);
        // First strobe one cycle after the press pulse.
        // Repeats need the level still high the cycle before they fire.
        want_idx.push_back(s + 2 + DB + 1);
        bound = s + 30 + 1 + DB;
        if (REPEAT_ON) begin
            t = s + 2 + DB + 1 + RD;
            while (t <= bound) begin
                want_idx.push_back(t);
                t += RP;
            end
        end
        foreach (stim_q[k]) begin
            tick(stim_q[k][0], stim_q[k][1], stim_q[k][2]);
            n_vec++;
            if (obs_vec !== exp_vec) begin
                n_err++;
                $display("FAIL repeat_model idx %0d: got %b want %b", k, obs_vec, exp_vec);
            end
            if (bif.inc_pulse === 1'b1) got_idx.push_back(k);
        end
        n_vec++;
        if (got_idx.size() != want_idx.size()) begin
            n_err++;
            $display("FAIL repeat_count: got %0d want %0d", got_idx.size(), want_idx.size());
        end
        for (int j = 0; j < want_idx.size(); j++) begin
            n_vec++;
            if (j >= got_idx.size() || got_idx[j] != want_idx[j]) begin
                n_err++;
                $display("FAIL repeat_time%0d: got %0d want %0d", j,
                         (j < got_idx.size()) ? got_idx[j] : -1, want_idx[j]);
            end
        end
        $display("test_auto_repeat: %0d inc pulses (repeat %0d)", got_idx.size(), REPEAT_ON);
    endtask

    task automatic test_simultaneous();
        int mp_both = 0;
        int inc_cnt = 0;
        int both_start;
        stim_q.delete();
        push_seg(0, 0, 0, 2);
        push_seg(1, 0, 0, 8);
        for (int p = 0; p < 3; p++) push_press(1, 0, 8, 8);
        both_start = stim_q.size();
        push_press(1, 1, 20, 10);
        foreach (stim_q[k]) begin
            tick(stim_q[k][0], stim_q[k][1], stim_q[k][2]);
            n_vec++;
            if (obs_vec !== exp_vec) begin
                n_err++;
                $display("FAIL simul_model idx %0d: got %b want %b", k, obs_vec, exp_vec);
            end
            if (bif.mode_pulse === 1'b1 && k >= both_start) mp_both++;
            if (bif.inc_pulse === 1'b1) inc_cnt++;
        end
        n_vec++;
        if (mp_both != 1) begin
            n_err++;
            $display("FAIL simul_mode_pulse: got %0d want 1", mp_both);
        end
        n_vec++;
        if (inc_cnt != 0) begin
            n_err++;
            $display("FAIL simul_inc: got %0d want 0", inc_cnt);
        end
        n_vec++;
        if ({bif.mode, bif.run_en} !== 3'b001) begin
            n_err++;
            $display("FAIL simul_final {mode,run_en}: got %b want 001", {bif.mode, bif.run_en});
        end
        $display("test_simultaneous: mode pulses %0d, inc pulses %0d", mp_both, inc_cnt);
    endtask

    task automatic test_random();
        logic m_lvl = 0, i_lvl = 0;
        int   m_left = 4, i_left = 4, rst_left = 2;
        int   bad = 0;
        for (int k = 0; k < 3000; k++) begin
            if (rst_left == 0 && $urandom_range(0, 599) == 0) rst_left = $urandom_range(1, 3);
            if (m_left == 0) begin m_lvl = ~m_lvl; m_left = $urandom_range(1, 14); end
            if (i_left == 0) begin i_lvl = ~i_lvl; i_left = $urandom_range(1, 40); end
            tick(m_lvl, i_lvl, rst_left == 0);
            if (rst_left > 0) rst_left--;
            m_left--;
            i_left--;
            n_vec++;
            if (obs_vec !== exp_vec) begin
                n_err++;
                bad++;
                $display("FAIL random_model cyc %0d: got %b want %b", k, obs_vec, exp_vec);
            end
        end
        $display("test_random: 3000 cycles, %0d differences", bad);
    endtask

    initial begin
        bif.btn_mode = 1'b0;
        bif.btn_inc  = 1'b0;
        test_reset();
        test_debounce();
        test_mode_wrap();
        test_inc_gating();
        test_auto_repeat();
        test_simultaneous();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
